// File: rtl/apb_timer_if.sv
// rtl/apb_timer_if.sv - APB bus bundle between the bridge and the timer
// master drives: paddr, psel, penable, pwrite, pwdata
// slave drives:  prdata, pready, pslverr
interface apb_timer_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_timer.sv
// rtl/apb_timer.sv - APB slave 32-bit timer with prescaler, compare match and level irq
// pclk      : block clock
// prstn     : asynchronous active-low reset
// apb       : APB slave port (paddr/psel/penable/pwrite/pwdata in, prdata/pready/pslverr out)
// timer_irq : level interrupt, registered MATCH & IRQ_EN
// Registers: 0x00 CTRL {IRQ_EN,PERIODIC,EN}, 0x04 PRESCALE, 0x08 LOAD, 0x0C COUNT, 0x10 STATUS (W1C MATCH)
module apb_timer #(
  parameter int ADDR_W = 12,
  parameter int PRE_W  = 16
) (
  input  logic       pclk,
  input  logic       prstn,
  apb_timer_if.slave apb,
  output logic       timer_irq
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } bus_state_t;

  localparam logic [ADDR_W-1:0] OFF_CTRL     = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] OFF_PRESCALE = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] OFF_LOAD     = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] OFF_COUNT    = ADDR_W'(32'h0C);
  localparam logic [ADDR_W-1:0] OFF_STATUS   = ADDR_W'(32'h10);

  // Bus side state
  bus_state_t  bus_state;
  logic [31:0] prdata_q;

  // Timer registers
  logic             ctrl_en;
  logic             ctrl_periodic;
  logic             ctrl_irq_en;
  logic [PRE_W-1:0] prescale;
  logic [PRE_W-1:0] pre_cnt;
  logic [31:0]      load;
  logic [31:0]      count;
  logic             match;
  logic             irq_q;

  // Decode
  logic [ADDR_W-1:0] offset;
  logic              sel_ctrl;
  logic              sel_prescale;
  logic              sel_load;
  logic              sel_count;
  logic              sel_status;
  logic              addr_valid;
  logic              setup_phase;
  logic              access_phase;
  logic              wr_commit;
  logic              wr_ctrl;
  logic              wr_prescale;
  logic              wr_load;
  logic              wr_count;
  logic              wr_status;
  logic [31:0]       rd_mux;
  logic              unused_addr_hi;

  // Counter control
  logic tick;
  logic at_load;
  logic hit;
  logic en_rise;

  // Only the low ADDR_W bits are decoded; psel already selected this slave.
  assign offset         = apb.paddr[ADDR_W-1:0];
  assign unused_addr_hi = ^apb.paddr[31:ADDR_W];

  // Every legal offset is word aligned, so an exact match also rejects paddr[1:0] != 0.
  assign sel_ctrl     = (offset == OFF_CTRL);
  assign sel_prescale = (offset == OFF_PRESCALE);
  assign sel_load     = (offset == OFF_LOAD);
  assign sel_count    = (offset == OFF_COUNT);
  assign sel_status   = (offset == OFF_STATUS);
  assign addr_valid   = sel_ctrl | sel_prescale | sel_load | sel_count | sel_status;

  assign setup_phase  = apb.psel & ~apb.penable;
  assign access_phase = apb.psel &  apb.penable;

  // Zero wait states: pready/pslverr follow the access phase directly.
  assign apb.pready  = access_phase;
  assign apb.pslverr = access_phase & ~addr_valid;
  assign apb.prdata  = prdata_q;

  // A write only commits when its access phase follows a registered SETUP, so a
  // transfer cut short by reset cannot complete on the first edge after release.
  assign wr_commit   = access_phase & apb.pwrite & addr_valid & (bus_state == SETUP);
  assign wr_ctrl     = wr_commit & sel_ctrl;
  assign wr_prescale = wr_commit & sel_prescale;
  assign wr_load     = wr_commit & sel_load;
  assign wr_count    = wr_commit & sel_count;
  assign wr_status   = wr_commit & sel_status;

  always_comb begin
    rd_mux = '0;
    if (sel_ctrl) begin
      rd_mux = {29'd0, ctrl_irq_en, ctrl_periodic, ctrl_en};
    end else if (sel_prescale) begin
      rd_mux = 32'(prescale);
    end else if (sel_load) begin
      rd_mux = load;
    end else if (sel_count) begin
      rd_mux = count;
    end else if (sel_status) begin
      rd_mux = {31'd0, match};
    end
  end

  // Bus FSM. bus_state holds the phase seen in the cycle that just ended;
  // read data is captured at the end of SETUP and held through ACCESS.
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      bus_state <= IDLE;
      prdata_q  <= '0;
    end else begin
      if (setup_phase) begin
        bus_state <= SETUP;
        prdata_q  <= apb.pwrite ? 32'd0 : rd_mux;
      end else if (access_phase) begin
        bus_state <= ACCESS;
      end else begin
        bus_state <= IDLE;
      end
    end
  end

  assign tick    = ctrl_en & (pre_cnt == prescale);
  assign at_load = (count == load);
  assign hit     = tick & at_load;
  assign en_rise = wr_ctrl & apb.pwdata[0] & ~ctrl_en;

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      ctrl_en       <= 1'b0;
      ctrl_periodic <= 1'b0;
      ctrl_irq_en   <= 1'b0;
      prescale      <= '0;
      pre_cnt       <= '0;
      load          <= '0;
      count         <= '0;
      match         <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      // Prescaler restarts on any write that redefines the count phase.
      if (wr_count || wr_prescale || en_rise) begin
        pre_cnt <= '0;
      end else if (ctrl_en) begin
        pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
      end

      // A bus write to COUNT beats a same-cycle tick.
      if (wr_count) begin
        count <= apb.pwdata;
      end else if (tick) begin
        if (!at_load) begin
          count <= count + 32'd1;
        end else if (ctrl_periodic) begin
          count <= '0;
        end
      end

      // A bus CTRL write beats the one-shot hardware EN clear.
      if (wr_ctrl) begin
        ctrl_en       <= apb.pwdata[0];
        ctrl_periodic <= apb.pwdata[1];
        ctrl_irq_en   <= apb.pwdata[2];
      end else if (hit && !ctrl_periodic) begin
        ctrl_en <= 1'b0;
      end

      if (wr_prescale) begin
        prescale <= apb.pwdata[PRE_W-1:0];
      end

      if (wr_load) begin
        load <= apb.pwdata;
      end

      // Hardware set beats a same-cycle W1C clear.
      if (hit) begin
        match <= 1'b1;
      end else if (wr_status && apb.pwdata[0]) begin
        match <= 1'b0;
      end

      irq_q <= match & ctrl_irq_en;
    end
  end

  assign timer_irq = irq_q;

endmodule

// File: tb/tb_apb_timer.sv
// tb/tb_apb_timer.sv - self-checking bench for apb_timer
module tb_apb_timer;

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_PRE    = 32'h04;
  localparam logic [31:0] A_LOAD   = 32'h08;
  localparam logic [31:0] A_COUNT  = 32'h0C;
  localparam logic [31:0] A_STATUS = 32'h10;

  logic pclk  = 1'b0;
  logic prstn = 1'b0;
  logic timer_irq;

  always #5 pclk = ~pclk;

  apb_timer_if bus();

  apb_timer #(.ADDR_W(12), .PRE_W(16)) dut (
    .pclk      (pclk),
    .prstn     (prstn),
    .apb       (bus),
    .timer_irq (timer_irq)
  );

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int last_commit = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    logic        exp_err;
  } vec_t;

  localparam int NV = 27;
  vec_t vt [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err);
    @(negedge pclk);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = addr;
    bus.pwdata  = wdata;
    #1 check("pready_setup", 32'(bus.pready), 32'd0);
    @(negedge pclk);
    bus.penable = 1'b1;
    #1;
    rdata = bus.prdata;
    err   = bus.pslverr;
    check("pready_access", 32'(bus.pready), 32'd1);
    @(posedge pclk);
    #1;
    last_commit = cyc;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] rd;
    logic        er;
    xfer(1'b1, addr, data, rd, er);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        er;
    xfer(1'b0, addr, 32'd0, rd, er);
    check(name, rd, exp);
    check({name, "_err"}, 32'(er), 32'd0);
  endtask

  // Returns the index of the clock edge after which timer_irq reached level, or -1.
  task automatic wait_irq(input logic level, input int budget, output int idx);
    idx = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge pclk);
      if (timer_irq === level) begin
        idx = cyc;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          e0;
    int          idx;
    int          c;
    int          m;
    int          p, l, c0, per, n, t;

    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = '0;
    bus.pwdata  = '0;

    vt[0]  = '{1'b0, 32'h000, 32'h0,        32'h0,        1'b0};
    vt[1]  = '{1'b0, 32'h004, 32'h0,        32'h0,        1'b0};
    vt[2]  = '{1'b0, 32'h008, 32'h0,        32'h0,        1'b0};
    vt[3]  = '{1'b0, 32'h00C, 32'h0,        32'h0,        1'b0};
    vt[4]  = '{1'b0, 32'h010, 32'h0,        32'h0,        1'b0};
    vt[5]  = '{1'b1, 32'h004, 32'hFFFF1234, 32'h0,        1'b0};
    vt[6]  = '{1'b0, 32'h004, 32'h0,        32'h00001234, 1'b0};
    vt[7]  = '{1'b1, 32'h008, 32'hCAFEF00D, 32'h0,        1'b0};
    vt[8]  = '{1'b0, 32'h008, 32'h0,        32'hCAFEF00D, 1'b0};
    vt[9]  = '{1'b1, 32'h000, 32'hFFFFFFF8, 32'h0,        1'b0};
    vt[10] = '{1'b0, 32'h000, 32'h0,        32'h0,        1'b0};
    vt[11] = '{1'b1, 32'h000, 32'h00000006, 32'h0,        1'b0};
    vt[12] = '{1'b0, 32'h000, 32'h0,        32'h00000006, 1'b0};
    vt[13] = '{1'b0, 32'h014, 32'h0,        32'h0,        1'b1};
    vt[14] = '{1'b1, 32'h0FC, 32'h0000DEAD, 32'h0,        1'b1};
    vt[15] = '{1'b0, 32'h0FC, 32'h0,        32'h0,        1'b1};
    vt[16] = '{1'b0, 32'h002, 32'h0,        32'h0,        1'b1};
    vt[17] = '{1'b1, 32'h009, 32'h00000001, 32'h0,        1'b1};
    vt[18] = '{1'b1, 32'h005, 32'h00000077, 32'h0,        1'b1};
    vt[19] = '{1'b0, 32'h008, 32'h0,        32'hCAFEF00D, 1'b0};
    vt[20] = '{1'b0, 32'h004, 32'h0,        32'h00001234, 1'b0};
    vt[21] = '{1'b0, 32'h1008, 32'h0,       32'hCAFEF00D, 1'b0};
    vt[22] = '{1'b1, 32'h00C, 32'h12345678, 32'h0,        1'b0};
    vt[23] = '{1'b0, 32'h00C, 32'h0,        32'h12345678, 1'b0};
    vt[24] = '{1'b1, 32'h000, 32'h0,        32'h0,        1'b0};
    vt[25] = '{1'b1, 32'h004, 32'h0,        32'h0,        1'b0};
    vt[26] = '{1'b1, 32'h00C, 32'h0,        32'h0,        1'b0};

    // Reset state
    repeat (3) @(negedge pclk);
    check("rst_prdata",  bus.prdata,           32'd0);
    check("rst_pready",  32'(bus.pready),      32'd0);
    check("rst_pslverr", 32'(bus.pslverr),     32'd0);
    check("rst_irq",     32'(timer_irq),       32'd0);
    prstn = 1'b1;

    // Register access vectors
    for (int i = 0; i < NV; i++) begin
      xfer(vt[i].wr, vt[i].addr, vt[i].data, rd, er);
      if (!vt[i].wr) check($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
      check($sformatf("vec%0d_pslverr", i), 32'(er), 32'(vt[i].exp_err));
    end

    // Periodic: PRESCALE=3, LOAD=4 -> 20 cycle period
    wr(A_PRE, 32'd3);
    wr(A_LOAD, 32'd4);
    wr(A_COUNT, 32'd0);
    wr(A_CTRL, 32'h7);
    e0 = last_commit;
    wait_irq(1'b1, 100, idx);
    check("per_irq_rise", 32'(idx), 32'(e0 + 21));
    wr(A_STATUS, 32'h1);
    check("w1c_irq_still_high", 32'(timer_irq), 32'd1);
    @(posedge pclk); #1;
    check("w1c_irq_fall", 32'(timer_irq), 32'd0);
    // W1C landing exactly on the second match edge
    m = e0 + 40;
    do @(negedge pclk); while (cyc < m - 3);
    wr(A_STATUS, 32'h1);
    @(posedge pclk); #1;
    check("w1c_on_tick_irq", 32'(timer_irq), 32'd1);
    rd_chk("w1c_on_tick_status", A_STATUS, 32'd1);
    // COUNT sampled at random times against the closed-form periodic count
    for (int k = 0; k < 6; k++) begin
      @(negedge pclk);
      repeat ($urandom_range(0, 25)) @(negedge pclk);
      c = cyc;
      rd_chk($sformatf("per_count%0d", k), A_COUNT, 32'(((c + 1 - e0) / 4) % 5));
    end
    wr(A_CTRL, 32'h0);

    // One-shot: PRESCALE=0, LOAD=10
    wr(A_STATUS, 32'h1);
    wr(A_PRE, 32'd0);
    wr(A_LOAD, 32'd10);
    wr(A_COUNT, 32'd0);
    wr(A_CTRL, 32'h5);
    e0 = last_commit;
    wait_irq(1'b1, 100, idx);
    check("os_irq_rise", 32'(idx), 32'(e0 + 12));
    rd_chk("os_ctrl", A_CTRL, 32'h4);
    rd_chk("os_count", A_COUNT, 32'd10);
    repeat (20) @(negedge pclk);
    rd_chk("os_count_hold", A_COUNT, 32'd10);
    rd_chk("os_status", A_STATUS, 32'd1);

    // Reset during the access phase of a COUNT write
    check("pre_reset_irq", 32'(timer_irq), 32'd1);
    @(negedge pclk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = A_COUNT; bus.pwdata = 32'h55;
    @(negedge pclk);
    bus.penable = 1'b1;
    #2 prstn = 1'b0;
    #1 check("async_rst_irq", 32'(timer_irq), 32'd0);
    @(posedge pclk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    @(negedge pclk);
    prstn = 1'b1;
    rd_chk("rst_count", A_COUNT, 32'd0);
    rd_chk("rst_ctrl", A_CTRL, 32'd0);
    rd_chk("rst_status", A_STATUS, 32'd0);
    check("rst_irq_after", 32'(timer_irq), 32'd0);

    // Randomized configurations against closed-form match times
    for (int it = 0; it < 8; it++) begin
      p   = $urandom_range(0, 3);
      l   = $urandom_range(4, 9);
      c0  = $urandom_range(0, l);
      per = $urandom_range(0, 1);
      wr(A_CTRL, 32'h0);
      wr(A_STATUS, 32'h1);
      wr(A_PRE, 32'(p));
      wr(A_LOAD, 32'(l));
      wr(A_COUNT, 32'(c0));
      wr(A_CTRL, 32'h5 | 32'(per << 1));
      e0 = last_commit;
      n  = (l - c0 + 1) * (p + 1);
      t  = (l + 1) * (p + 1);
      wait_irq(1'b1, n + 20, idx);
      check($sformatf("rnd%0d_first", it), 32'(idx), 32'(e0 + n + 1));
      if (per != 0) begin
        wr(A_STATUS, 32'h1);
        wait_irq(1'b0, 10, idx);
        wait_irq(1'b1, t + 20, idx);
        check($sformatf("rnd%0d_second", it), 32'(idx), 32'(e0 + n + t + 1));
      end else begin
        rd_chk($sformatf("rnd%0d_count", it), A_COUNT, 32'(l));
        rd_chk($sformatf("rnd%0d_ctrl", it), A_CTRL, 32'h4);
      end
    end

    // COUNT wraps 0xFFFF_FFFF -> 0 on its way to LOAD
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'h1);
    wr(A_PRE, 32'd0);
    wr(A_LOAD, 32'd5);
    wr(A_COUNT, 32'hFFFFFFFE);
    wr(A_CTRL, 32'h5);
    e0 = last_commit;
    wait_irq(1'b1, 50, idx);
    check("wrap_irq_rise", 32'(idx), 32'(e0 + 9));
    rd_chk("wrap_count", A_COUNT, 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
